// File: rtl/fcvt_s_w_seq.sv
// Sequential int32 -> binary32 converter (fcvt.s.w / fcvt.s.wu).
// Normalizes one bit per cycle, then rounds to nearest-even.
module fcvt_s_w_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic        is_unsigned,
    input  logic        kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        nx
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] out_q, out_d;
    logic        nx_q, nx_d;

    logic        accept;
    logic        lsb, guard, sticky, up;
    logic [30:0] rounded;

    assign in_ready  = (state_q == StIdle) && !kill;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign out       = out_q;
    assign nx        = nx_q;

    assign lsb     = mag_q[8];
    assign guard   = mag_q[7];
    assign sticky  = |mag_q[6:0];
    assign up      = guard & (sticky | lsb);
    // Mantissa overflow carries straight into the exponent field.
    assign rounded = {exp_q, mag_q[30:8]} + {30'd0, up};

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        out_d   = out_q;
        nx_d    = nx_q;
        if (kill) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        sign_d = !is_unsigned & rs1[31];
                        mag_d  = sign_d ? (~rs1 + 32'd1) : rs1;
                        exp_d  = 8'd158;
                        if (mag_d == 32'd0) begin
                            out_d   = 32'd0;
                            nx_d    = 1'b0;
                            state_d = StDone;
                        end else begin
                            state_d = StNorm;
                        end
                    end
                end
                StNorm: begin
                    if (mag_q[31]) begin
                        state_d = StRound;
                    end else begin
                        mag_d = mag_q << 1;
                        exp_d = exp_q - 8'd1;
                    end
                end
                StRound: begin
                    out_d   = {sign_q, rounded};
                    nx_d    = guard | sticky;
                    state_d = StDone;
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            mag_q   <= 32'd0;
            exp_q   <= 8'd0;
            sign_q  <= 1'b0;
            out_q   <= 32'd0;
            nx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
            nx_q    <= nx_d;
        end
    end

endmodule

// File: doc/fcvt_s_w_seq.md
# fcvt_s_w_seq

Multi-cycle integer-to-single-precision converter controller for the FP unit. It accepts one 32-bit integer operand per transaction, signed (fcvt.s.w) or unsigned (fcvt.s.wu), over a valid/ready handshake. It normalizes the operand with a one-bit-per-cycle shift sequencer, applies round-to-nearest-even and returns an IEEE-754 binary32 result plus the inexact flag. It sits between the issue stage and FP writeback and serializes conversions onto a single shared shifter/rounder.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept; combinational, (state==IDLE) && !kill.
- rs1  input  32  integer operand; sampled at accept.
- is_unsigned  input  1  1 = fcvt.s.wu, 0 = fcvt.s.w; sampled at accept.
- kill  input  1  synchronous abort of the in-flight conversion.
- out_valid  output  1  result valid; registered.
- out_ready  input  1  consumer takes the result.
- out  output  32  binary32 result; registered.
- nx  output  1  inexact flag for `out`; registered.

## Operation
- States: IDLE, NORM, ROUND, DONE. Reset state is IDLE.
- IDLE: an accept occurs when in_valid && in_ready.
  - Capture sign = !is_unsigned & rs1[31].
  - Capture mag = sign ? (~rs1 + 1) : rs1, 32 bits. Signed 0x80000000 yields mag 0x80000000.
  - Set exp = 8'd158 (127 + 31).
  - If mag == 0: load out = 32'h0 and nx = 0, then go to DONE. Integer zero always gives +0.
  - Otherwise go to NORM.
- NORM: each cycle, if mag[31] == 0, then mag <= mag << 1 and exp <= exp - 1. If mag[31] == 1, go to ROUND with no shift. Exp never underflows (minimum 127).
- ROUND:
  - lsb = mag[8], guard = mag[7], sticky = |mag[6:0].
  - up = guard & (sticky | lsb).
  - {e, m} = {exp, mag[30:8]} + up, as a 31-bit add. Mantissa carry propagates into the exponent. Maximum exponent is 159, so no infinity is possible.
  - Load out <= {sign, e, m} and nx <= guard | sticky, then go to DONE.
- DONE: out_valid = 1. Out and nx stay stable until out_valid && out_ready, then go to IDLE. There is no accept in the same cycle as the DONE handshake.
- kill:
  - Highest priority. In any state, a kill sampled high forces IDLE at the next edge and drops out_valid, including in DONE with out_ready high.
  - in_ready is low while kill is high, so no accept happens in a kill cycle.
  - out and nx keep their last values after kill.
- Reset (async, any state, including mid-NORM): state = IDLE, out_valid = 0, out = 0, nx = 0, internal mag/exp/sign = 0. in_ready is high after reset once kill is low.

## Timing
- Let lz be the leading-zero count of mag (0..31). The accept edge is edge 1.
- Nonzero operand: lz shift edges, then one NORM→ROUND edge, then one ROUND→DONE edge. out_valid rises after edge lz+3: 3 cycles minimum, 34 maximum.
- Zero operand: out_valid rises after edge 1.
- Throughput is one conversion in flight. The next accept happens no earlier than the cycle after the DONE handshake edge.
- out_valid is held indefinitely under out_ready = 0, with out and nx unchanged.
- in_ready does not depend on in_valid, so there is no combinational loop.

## Test plan
- Unsigned 1 → out 0x3F800000, nx 0, out_valid after exactly 34 edges. Unsigned 0x00800000 → 0x4B000000, out_valid after 11 edges.
- Signed 0xFFFFFFFF → 0xBF800000, nx 0. Unsigned 0xFFFFFFFF → 0x4F800000, nx 1 (round carries into exponent), latency 3 edges.
- Signed 0x80000000 → 0xCF000000, nx 0. Unsigned 0x80000000 → 0x4F000000. Zero in either mode → 0x00000000 after 1 edge.
- RNE ties: unsigned 0x01000001 → 0x4B800000 (tie to even, round down), nx 1. Unsigned 0x01000003 → 0x4B800002 (tie, round up), nx 1. Signed 0xFEFFFFFF → 0xCB800000 (mag 0x01000001, tie to even round down), nx 1.
- Handshake: hold out_ready = 0 for 10 cycles in DONE.
  - out, nx and out_valid must stay stable, and in_ready must stay 0.
  - A new in_valid pulse during DONE must be ignored.
  - The DONE handshake is followed by in_ready = 1 in the next cycle.
- Abort and reset:
  - kill asserted 5 cycles into NORM for operand 1: the next cycle is IDLE with in_ready = 1, and out_valid never rises.
  - kill together with in_valid in IDLE: no accept.
  - resetn pulsed low mid-NORM: out_valid = 0 and out = 0 immediately. A following accept of 7 gives 0x40E00000.
